// File: rtl/jt900h_cregs_pkg.sv
// rtl/jt900h_cregs_pkg.sv - micro-DMA control register map, mode and size codes
package jt900h_cregs_pkg;

  localparam logic [7:0] DMAS_CRA = 8'h00;
  localparam logic [7:0] DMAD_CRA = 8'h10;
  localparam logic [7:0] DMAC_CRA = 8'h20;
  localparam logic [7:0] DMAM_CRA = 8'h22;

  localparam logic [2:0] DINC_MODE = 3'd0;
  localparam logic [2:0] DDEC_MODE = 3'd1;
  localparam logic [2:0] SINC_MODE = 3'd2;
  localparam logic [2:0] SDEC_MODE = 3'd3;
  localparam logic [2:0] FIX_MODE  = 3'd4;
  localparam logic [2:0] CNT_MODE  = 3'd5;

  localparam logic [1:0] SIZE_BYTE = 2'd0;
  localparam logic [1:0] SIZE_WORD = 2'd1;
  localparam logic [1:0] SIZE_LONG = 2'd2;

  typedef enum logic [2:0] {
    CR_NONE,
    CR_DMAS,
    CR_DMAD,
    CR_DMAC,
    CR_DMAM
  } cr_kind_t;

  typedef struct packed {
    cr_kind_t   kind;
    logic [1:0] ch;
  } cr_sel_t;

  // Channel number sits in cra[3:2] for every register group
  function automatic cr_sel_t cr_decode(input logic [7:0] a);
    cr_sel_t s;
    s.kind = CR_NONE;
    s.ch   = a[3:2];
    if (a[7:4] == DMAS_CRA[7:4] && a[1:0] == DMAS_CRA[1:0]) s.kind = CR_DMAS;
    if (a[7:4] == DMAD_CRA[7:4] && a[1:0] == DMAD_CRA[1:0]) s.kind = CR_DMAD;
    if (a[7:4] == DMAC_CRA[7:4] && a[1:0] == DMAC_CRA[1:0]) s.kind = CR_DMAC;
    if (a[7:4] == DMAM_CRA[7:4] && a[1:0] == DMAM_CRA[1:0]) s.kind = CR_DMAM;
    return s;
  endfunction

endpackage

// File: rtl/jt900h_cregs_step.sv
// rtl/jt900h_cregs_step.sv - next source/destination address for one transfer
module jt900h_cregs_step
  import jt900h_cregs_pkg::*;
(
  input  logic [2:0]  mode,
  input  logic [1:0]  size,
  input  logic [23:0] cur_src,
  input  logic [23:0] cur_dst,
  output logic [23:0] nxt_src,
  output logic [23:0] nxt_dst
);

  logic [23:0] step;

  always_comb begin
    case (size)
      SIZE_WORD: step = 24'd2;
      SIZE_LONG: step = 24'd4;
      default:   step = 24'd1;
    endcase
    nxt_src = cur_src;
    nxt_dst = cur_dst;
    // 24-bit arithmetic wraps naturally; unknown modes behave as fixed
    case (mode)
      DINC_MODE: nxt_dst = cur_dst + step;
      DDEC_MODE: nxt_dst = cur_dst - step;
      SINC_MODE: nxt_src = cur_src + step;
      SDEC_MODE: nxt_src = cur_src - step;
      CNT_MODE:  nxt_src = cur_src + 24'd1;
      default: ;
    endcase
  end

endmodule

// File: rtl/jt900h_cregs.sv
// rtl/jt900h_cregs.sv - micro-DMA channel control registers with update pipeline
module jt900h_cregs
  import jt900h_cregs_pkg::*;
#(
  parameter int CH = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        cen,
  input  logic [7:0]  cra,
  input  logic [31:0] crin,
  input  logic        cr_we,
  output logic [31:0] cr,
  input  logic        upd,
  input  logic [1:0]  upd_ch,
  output logic [23:0] src,
  output logic [23:0] dst,
  output logic [1:0]  size,
  output logic        done,
  output logic [1:0]  done_ch
);

  logic [23:0] dmas [CH];
  logic [23:0] dmad [CH];
  logic [15:0] dmac [CH];
  logic [4:0]  dmam [CH];

  logic        s1_v;
  logic [1:0]  s1_ch;
  logic [4:0]  s1_mode;

  cr_sel_t     sel;
  logic        cpu_we;
  logic        hit_s, hit_d, hit_c;
  logic [23:0] stp_src, stp_dst;
  logic [23:0] nxt_src, nxt_dst;
  logic [15:0] nxt_cnt;
  logic        fwd;
  logic        unused_crin;

  assign sel         = cr_decode(cra);
  assign cpu_we      = cr_we & cen;
  assign unused_crin = ^crin[31:24];

  always_comb begin
    case (sel.kind)
      CR_DMAS: cr = {8'd0, dmas[sel.ch]};
      CR_DMAD: cr = {8'd0, dmad[sel.ch]};
      CR_DMAC: cr = {16'd0, dmac[sel.ch]};
      CR_DMAM: cr = {27'd0, dmam[sel.ch]};
      default: cr = 32'd0;
    endcase
  end

  jt900h_cregs_step u_step (
    .mode    (s1_mode[4:2]),
    .size    (s1_mode[1:0]),
    .cur_src (dmas[s1_ch]),
    .cur_dst (dmad[s1_ch]),
    .nxt_src (stp_src),
    .nxt_dst (stp_dst)
  );

  // A CPU write landing on the stage-2 channel overrides that field only
  assign hit_s = cpu_we && sel.kind == CR_DMAS && sel.ch == s1_ch;
  assign hit_d = cpu_we && sel.kind == CR_DMAD && sel.ch == s1_ch;
  assign hit_c = cpu_we && sel.kind == CR_DMAC && sel.ch == s1_ch;

  assign nxt_src = hit_s ? crin[23:0] : stp_src;
  assign nxt_dst = hit_d ? crin[23:0] : stp_dst;
  assign nxt_cnt = hit_c ? crin[15:0] : dmac[s1_ch] - 16'd1;

  assign fwd  = s1_v && s1_ch == upd_ch;
  assign src  = fwd ? nxt_src : dmas[upd_ch];
  assign dst  = fwd ? nxt_dst : dmad[upd_ch];
  assign size = dmam[upd_ch][1:0];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < CH; i++) begin
        dmas[i] <= 24'd0;
        dmad[i] <= 24'd0;
        dmac[i] <= 16'd0;
        dmam[i] <= 5'd0;
      end
      s1_v    <= 1'b0;
      s1_ch   <= 2'd0;
      s1_mode <= 5'd0;
      done    <= 1'b0;
      done_ch <= 2'd0;
    end else if (cen) begin
      s1_v    <= upd;
      s1_ch   <= upd_ch;
      s1_mode <= dmam[upd_ch];
      done    <= s1_v && !hit_c && nxt_cnt == 16'd0;
      done_ch <= s1_ch;
      if (s1_v) begin
        dmas[s1_ch] <= nxt_src;
        dmad[s1_ch] <= nxt_dst;
        dmac[s1_ch] <= nxt_cnt;
      end
      if (cr_we) begin
        case (sel.kind)
          CR_DMAS: dmas[sel.ch] <= crin[23:0];
          CR_DMAD: dmad[sel.ch] <= crin[23:0];
          CR_DMAC: dmac[sel.ch] <= crin[15:0];
          CR_DMAM: dmam[sel.ch] <= crin[4:0];
          default: ;
        endcase
      end
    end else begin
      done <= 1'b0;
    end
  end

endmodule

// File: tb/tb_jt900h_cregs.sv
// tb/tb_jt900h_cregs.sv - directed vector bench for jt900h_cregs
module tb_jt900h_cregs;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        cen;
  logic [7:0]  cra;
  logic [31:0] crin;
  logic        cr_we;
  logic [31:0] cr;
  logic        upd;
  logic [1:0]  upd_ch;
  logic [23:0] src;
  logic [23:0] dst;
  logic [1:0]  size;
  logic        done;
  logic [1:0]  done_ch;

  int n_chk  = 0;
  int n_pass = 0;

  jt900h_cregs #(.CH(4)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .cen     (cen),
    .cra     (cra),
    .crin    (crin),
    .cr_we   (cr_we),
    .cr      (cr),
    .upd     (upd),
    .upd_ch  (upd_ch),
    .src     (src),
    .dst     (dst),
    .size    (size),
    .done    (done),
    .done_ch (done_ch)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0]  cra;
    logic [31:0] crin;
    logic [31:0] exp;
  } wr_vec_t;

  typedef struct {
    logic [4:0]  mode;
    logic [23:0] s0;
    logic [23:0] d0;
    logic [23:0] es;
    logic [23:0] ed;
  } md_vec_t;

  wr_vec_t wv [6];
  md_vec_t mv [6];

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  task automatic wr(input logic [7:0] a, input logic [31:0] d);
    cra   = a;
    crin  = d;
    cr_we = 1'b1;
    tick();
    cr_we = 1'b0;
  endtask

  task automatic rd(input string name, input logic [7:0] a, input logic [31:0] exp);
    cra = a;
    @(negedge clk);
    chk(name, cr, exp);
    tick();
  endtask

  initial begin
    wv[0] = '{8'h04, 32'hAB123456, 32'h00123456};
    wv[1] = '{8'h24, 32'hFFFF1234, 32'h00001234};
    wv[2] = '{8'h26, 32'h000000FF, 32'h0000001F};
    wv[3] = '{8'h14, 32'hFFFFFFFF, 32'h00FFFFFF};
    wv[4] = '{8'h21, 32'h0000FFFF, 32'h00000000};
    wv[5] = '{8'h30, 32'h00000055, 32'h00000000};

    mv[0] = '{5'h0C, 24'h000000, 24'h000005, 24'hFFFFFF, 24'h000005};
    mv[1] = '{5'h05, 24'h000007, 24'h000001, 24'h000007, 24'hFFFFFF};
    mv[2] = '{5'h13, 24'h000100, 24'h000200, 24'h000100, 24'h000200};
    mv[3] = '{5'h1A, 24'h000300, 24'h000400, 24'h000300, 24'h000400};
    mv[4] = '{5'h03, 24'h000001, 24'h000010, 24'h000001, 24'h000011};
    mv[5] = '{5'h0A, 24'hFFFFFC, 24'h000009, 24'h000000, 24'h000009};

    rst_n = 1'b0; cen = 1'b1; cra = 8'h00; crin = 32'd0; cr_we = 1'b0;
    upd = 1'b0; upd_ch = 2'd0;
    tick(); tick();
    rst_n = 1'b1;

    // reset clears registers that were written
    wr(8'h00, 32'h00123456);
    wr(8'h20, 32'h00000055);
    wr(8'h22, 32'h00000001);
    rd("pre_reset_dmas0", 8'h00, 32'h00123456);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    chk("reset_done", {31'd0, done}, 32'd0);
    rd("reset_dmas0", 8'h00, 32'd0);
    rd("reset_dmac0", 8'h20, 32'd0);
    rd("reset_dmam0", 8'h22, 32'd0);

    for (int i = 0; i < 6; i++) begin
      wr(wv[i].cra, wv[i].crin);
      rd($sformatf("wr_rd_%0d", i), wv[i].cra, wv[i].exp);
    end

    // mode 000 long on channel 2 with destination wrap
    wr(8'h18, 32'h00FFFFFE);
    wr(8'h28, 32'h00000002);
    wr(8'h2A, 32'h00000002);
    upd = 1'b1; upd_ch = 2'd2;
    tick();
    upd = 1'b0;
    tick();
    chk("dinc_done1", {31'd0, done}, 32'd0);
    rd("dinc_dmad2_a", 8'h18, 32'h00000002);
    rd("dinc_dmac2_a", 8'h28, 32'h00000001);
    upd = 1'b1;
    tick();
    upd = 1'b0;
    tick();
    chk("dinc_done2", {31'd0, done}, 32'd1);
    chk("dinc_done_ch", {30'd0, done_ch}, 32'd2);
    tick();
    chk("dinc_done_pulse", {31'd0, done}, 32'd0);
    chk("size_out", {30'd0, size}, 32'd2);
    chk("dst_out", {8'd0, dst}, 32'h00000006);
    rd("dinc_dmad2_b", 8'h18, 32'h00000006);
    rd("dinc_dmac2_b", 8'h28, 32'h00000000);

    // back-to-back updates on channel 1 see forwarded values
    wr(8'h04, 32'h00000100);
    wr(8'h24, 32'h00000005);
    wr(8'h26, 32'h00000009);
    upd = 1'b1; upd_ch = 2'd1;
    tick();
    chk("fwd_src_out", {8'd0, src}, 32'h00000102);
    tick();
    upd = 1'b0;
    tick();
    rd("fwd_dmas1", 8'h04, 32'h00000104);
    rd("fwd_dmac1", 8'h24, 32'h00000003);

    // CPU write to DMAC3 collides with the stage-2 update
    wr(8'h0C, 32'h00000010);
    wr(8'h1C, 32'h00000020);
    wr(8'h2C, 32'h00000001);
    wr(8'h2E, 32'h00000000);
    upd = 1'b1; upd_ch = 2'd3;
    tick();
    upd = 1'b0;
    cra = 8'h2C; crin = 32'h00000007; cr_we = 1'b1;
    tick();
    cr_we = 1'b0;
    chk("coll_done", {31'd0, done}, 32'd0);
    rd("coll_dmac3", 8'h2C, 32'h00000007);
    rd("coll_dmad3", 8'h1C, 32'h00000021);
    rd("coll_dmas3", 8'h0C, 32'h00000010);

    // count wrap in counter mode with cen stall
    wr(8'h00, 32'h00000000);
    wr(8'h20, 32'h00000000);
    wr(8'h22, 32'h00000016);
    upd = 1'b1; upd_ch = 2'd0;
    tick();
    upd = 1'b0;
    cen = 1'b0;
    tick(); tick();
    rd("stall_dmac0", 8'h20, 32'h00000000);
    chk("stall_done", {31'd0, done}, 32'd0);
    cen = 1'b1;
    tick();
    chk("wrap_done", {31'd0, done}, 32'd0);
    rd("wrap_dmac0", 8'h20, 32'h0000FFFF);
    rd("cnt_dmas0", 8'h00, 32'h00000001);

    for (int i = 0; i < 6; i++) begin
      wr(8'h00, {8'd0, mv[i].s0});
      wr(8'h10, {8'd0, mv[i].d0});
      wr(8'h20, 32'h00000003);
      wr(8'h22, {27'd0, mv[i].mode});
      upd = 1'b1; upd_ch = 2'd0;
      tick();
      upd = 1'b0;
      tick();
      rd($sformatf("mode_src_%0d", i), 8'h00, {8'd0, mv[i].es});
      rd($sformatf("mode_dst_%0d", i), 8'h10, {8'd0, mv[i].ed});
      rd($sformatf("mode_cnt_%0d", i), 8'h20, 32'h00000002);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
